// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock FIFO: storage array, wrap-bit pointer control and a registered
// read port. Reports occupancy, full/empty, programmable almost flags and
// sticky overflow/underflow. A synchronous flush (clr_i) empties the FIFO.
//
// Ports
//   clk_i            clock, all logic on posedge
//   rst_i            asynchronous active-high reset
//   clr_i            synchronous flush of pointers, flags and rd_valid
//   wr_en_i          write request
//   wr_data_i        write word
//   rd_en_i          read request
//   rd_data_o        registered read word (held when no read is accepted)
//   rd_valid_o       rd_data_o was loaded by a read accepted last cycle
//   full_o, empty_o  occupancy == DEPTH / occupancy == 0
//   almost_full_o    occupancy >= AF_THRESH
//   almost_empty_o   occupancy <= AE_THRESH
//   count_o          occupancy, 0..DEPTH
//   overflow_o       sticky: write attempted while full without a read
//   underflow_o      sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_T    = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_T    = AE_THRESH[ADDR_W:0];

    // Storage is deliberately left without reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit above the address bits.
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;
    logic full_w;
    logic empty_w;

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    // A write into a full FIFO is still accepted when a read frees a slot in
    // the same cycle. A read from an empty FIFO is never bypassed from the write.
    assign wr_acc = wr_en_i & (~full_w | rd_en_i);
    assign rd_acc = rd_en_i & ~empty_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_en_i & full_w & ~rd_en_i) begin
            overflow_d = 1'b1;
        end
        if (rd_en_i & empty_w) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr_i) begin
            // Flush wins over any request in the same cycle; rd_data_q is held.
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            // Non-blocking read sees the pre-write word when both pointers
            // share an address (full FIFO with simultaneous read and write).
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc && !clr_i && !rst_i) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    // Occupancy falls out of the pointer difference; the wrap bit makes
    // DEPTH representable.
    assign count_o        = wr_ptr_q - rd_ptr_q;
    assign full_o         = full_w;
    assign empty_o        = empty_w;
    assign almost_full_o  = (count_o >= AF_T);
    assign almost_empty_o = (count_o <= AE_T);
    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule
